mem_stage_mc: RTL

//  Parametrised MEM pipeline stage for a variable-latency data memory (cache/multi-cycle DMEM).

---
 rtl/mem_stage_mc.sv | 108 ++++++++++
 1 files changed

// File: rtl/mem_stage_mc.sv
// MEM pipeline stage for a variable-latency data memory: req/ack port, upstream stall,
// M/W register, access timeout, sticky timeout flag, halt freeze and a stall-cycle counter.
module mem_stage_mc #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int REG_W   = 4,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic [REG_W-1:0]  in_wr_reg,
  input  logic              in_mem_read,
  input  logic              in_mem_write,
  input  logic              in_reg_write,
  input  logic              in_memtoreg,
  input  logic              in_halt,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_alu,
  output logic [DATA_W-1:0] out_mem_data,
  output logic [REG_W-1:0]  out_wr_reg,
  output logic              out_reg_write,
  output logic              out_memtoreg,
  output logic              out_halt,
  output logic              err_timeout,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int WCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, HALTED} state_t;

  state_t            state;
  logic [WCNT_W-1:0] wait_cnt;
  logic              memop;
  logic              timeout_hit;
  logic              complete;
  logic              read_done;
  logic              halt_load;

  assign memop       = in_valid & (in_mem_read | in_mem_write);
  assign timeout_hit = (TIMEOUT != 0) && (state == WAIT) &&
                       (wait_cnt == WCNT_W'(TIMEOUT - 1)) && !mem_ack;
  assign complete    = mem_ack | timeout_hit;
  // Upstream holds in_* stable while stalled, so WAIT can drive the port straight from the inputs.
  assign stall       = !rst && (state != HALTED) && memop && !complete;
  assign mem_req     = !rst && (((state == IDLE) && memop) || (state == WAIT));
  assign mem_wr      = in_mem_write;
  assign mem_addr    = in_alu[ADDR_W-1:0];
  assign mem_wdata   = in_wdata;
  assign read_done   = memop && !in_mem_write && mem_ack;
  assign halt_load   = (state != HALTED) && !stall && in_valid && in_halt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      err_timeout   <= 1'b0;
      stall_cnt     <= '0;
      out_valid     <= 1'b0;
      out_alu       <= '0;
      out_mem_data  <= '0;
      out_wr_reg    <= '0;
      out_reg_write <= 1'b0;
      out_memtoreg  <= 1'b0;
      out_halt      <= 1'b0;
    end else begin
      if (state != HALTED) begin
        if (halt_load)  state <= HALTED;
        else if (stall) state <= WAIT;
        else            state <= IDLE;
      end

      if ((state == WAIT) && stall) wait_cnt <= wait_cnt + 1'b1;
      else                          wait_cnt <= '0;

      if (timeout_hit) err_timeout <= 1'b1;

      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;

      // Halted or stalled cycles push a bubble; data fields keep their last value.
      if ((state == HALTED) || stall) begin
        out_valid     <= 1'b0;
        out_reg_write <= 1'b0;
        out_halt      <= 1'b0;
      end else begin
        out_valid     <= in_valid;
        out_alu       <= in_alu;
        out_mem_data  <= read_done ? mem_rdata : '0;
        out_wr_reg    <= in_wr_reg;
        out_reg_write <= in_valid & in_reg_write;
        out_memtoreg  <= in_memtoreg;
        out_halt      <= in_valid & in_halt;
      end
    end
  end

endmodule
